// File: rtl/rv64g_l2_pkg.sv
// L2 directory controller shared types: op encoding, entry layout, FSM states
// and the per-entry update rule used by rv64g_l2_dir_ctrl.
package rv64g_l2_pkg;

  localparam int SETS  = 256;
  localparam int WAYS  = 16;
  localparam int CORES = 4;
  localparam int REQS  = 3;
  localparam int SW    = $clog2(SETS);
  localparam int WW    = $clog2(WAYS);
  localparam int CW    = $clog2(CORES);
  localparam int RW    = $clog2(REQS);

  typedef enum logic [1:0] {
    OP_READ        = 2'd0,
    OP_ADD_SHARER  = 2'd1,
    OP_SET_OWNER   = 2'd2,
    OP_REMOVE_CORE = 2'd3
  } dir_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } dir_state_e;

  typedef struct packed {
    logic             valid;
    logic [CORES-1:0] sharers;
    logic             owner_valid;
    logic [CW-1:0]    owner_id;
    logic             dirty;
  } dir_entry_t;

  typedef struct packed {
    dir_entry_t entry;
    logic       write;
    logic       conflict;
  } dir_upd_t;

  function automatic logic entry_bad(dir_entry_t e);
    return (e.owner_valid && (|e.sharers)) ||
           (e.dirty && !e.owner_valid);
  endfunction

  function automatic dir_upd_t dir_update(
    dir_entry_t    e,
    dir_op_e       op,
    logic [CW-1:0] core,
    logic          dirty
  );
    dir_upd_t         r;
    logic [CORES-1:0] b;
    b          = '0;
    b[core]    = 1'b1;
    r.entry    = e;
    r.write    = 1'b0;
    r.conflict = 1'b0;
    unique case (op)
      OP_READ: ;
      OP_ADD_SHARER: begin
        if (e.owner_valid && e.owner_id != core) begin
          r.conflict = 1'b1;
        end else begin
          r.entry.valid       = 1'b1;
          r.entry.sharers     = e.sharers | b;
          r.entry.owner_valid = 1'b0;
          r.entry.owner_id    = '0;
          r.entry.dirty       = 1'b0;
          r.write             = 1'b1;
        end
      end
      OP_SET_OWNER: begin
        r.entry.valid       = 1'b1;
        r.entry.sharers     = '0;
        r.entry.owner_valid = 1'b1;
        r.entry.owner_id    = core;
        r.entry.dirty       = dirty;
        r.write             = 1'b1;
      end
      OP_REMOVE_CORE: begin
        r.entry.sharers = e.sharers & ~b;
        if (e.owner_valid && e.owner_id == core) begin
          r.entry.owner_valid = 1'b0;
          r.entry.dirty       = 1'b0;
        end
        r.write = 1'b1;
      end
    endcase
    // Keep written entries well-formed even if the RAM held garbage.
    if (r.entry.owner_valid) r.entry.sharers = '0;
    if (!r.entry.owner_valid) r.entry.dirty = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/rv64g_rr_arbiter.sv
// Round-robin arbiter: one-hot grant while enabled, pointer moves
// past the winner on every grant.
module rv64g_rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] win_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_o = idx;
      end
    end
    if (found && en_i) gnt_o[win_o] = 1'b1;
    ptr_d = ptr_q;
    if (found && en_i) begin
      ptr_d = (win_o == PW'(N - 1)) ? '0 : win_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rv64g_l2_dir_ctrl.sv
// L2 directory read-modify-write sequencer, one op in flight.
// Define L2_DIR_CTRL_CHECK_EN to flag and refuse malformed entries.
module rv64g_l2_dir_ctrl
  import rv64g_l2_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQS-1:0]       req_valid_i,
  output logic [REQS-1:0]       req_ready_o,
  input  logic [REQS*SW-1:0]    req_set_i,
  input  logic [REQS*WW-1:0]    req_way_i,
  input  logic [REQS*2-1:0]     req_op_i,
  input  logic [REQS*CW-1:0]    req_core_i,
  input  logic [REQS-1:0]       req_dirty_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [RW-1:0]         resp_id_o,
  output logic                  resp_hit_o,
  output logic [CORES-1:0]      resp_sharers_o,
  output logic                  resp_owner_valid_o,
  output logic [CW-1:0]         resp_owner_id_o,
  output logic                  resp_dirty_o,
  output logic                  resp_conflict_o,
  output logic [SW-1:0]         dir_rd_set_o,
  input  logic [WAYS-1:0]       dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0] dir_rd_sharers_i,
  input  logic [WAYS-1:0]       dir_rd_owner_valid_i,
  input  logic [WAYS*CW-1:0]    dir_rd_owner_id_i,
  input  logic [WAYS-1:0]       dir_rd_dirty_i,
  output logic                  dir_we_o,
  output logic [SW-1:0]         dir_wr_set_o,
  output logic [WW-1:0]         dir_wr_way_o,
  output logic                  dir_wr_valid_o,
  output logic [CORES-1:0]      dir_wr_sharers_o,
  output logic                  dir_wr_owner_valid_o,
  output logic [CW-1:0]         dir_wr_owner_id_o,
  output logic                  dir_wr_dirty_o,
  output logic                  err_o
);

  dir_state_e    state_q, state_d;
  logic [SW-1:0] set_q, set_d;
  logic [WW-1:0] way_q, way_d;
  dir_op_e       op_q, op_d;
  logic [CW-1:0] core_q, core_d;
  logic          dirty_q, dirty_d;
  logic [RW-1:0] id_q, id_d;
  dir_entry_t    old_q, old_d;
  dir_entry_t    wr_q, wr_d;
  logic          we_q, we_d;
  logic          rv_q, rv_d;
  logic          cf_q, cf_d;
  logic          err_q, err_d;

  logic [REQS-1:0] gnt;
  logic [RW-1:0]   win;
  logic            arb_en;
  dir_entry_t      rd_e;
  dir_upd_t        upd;
  logic            chk_bad;

  // Reset gates the comb grant so no ready escapes while held in reset.
  assign arb_en = (state_q == ST_IDLE) && rst_n;

  rv64g_rr_arbiter #(.N(REQS), .PW(RW)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid_i),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .win_o (win)
  );

  assign req_ready_o = gnt;

  always_comb begin
    rd_e.valid       = dir_rd_valid_i[way_q];
    rd_e.sharers     = dir_rd_sharers_i[int'(way_q)*CORES +: CORES];
    rd_e.owner_valid = dir_rd_owner_valid_i[way_q];
    rd_e.owner_id    = dir_rd_owner_id_i[int'(way_q)*CW +: CW];
    rd_e.dirty       = dir_rd_dirty_i[way_q];
  end

  assign upd = dir_update(rd_e, op_q, core_q, dirty_q);

`ifdef L2_DIR_CTRL_CHECK_EN
  assign chk_bad = entry_bad(rd_e);
`else
  assign chk_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    op_d    = op_q;
    core_d  = core_q;
    dirty_d = dirty_q;
    id_d    = id_q;
    old_d   = old_q;
    wr_d    = wr_q;
    we_d    = we_q;
    rv_d    = rv_q;
    cf_d    = cf_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          set_d   = req_set_i[int'(win)*SW +: SW];
          way_d   = req_way_i[int'(win)*WW +: WW];
          op_d    = dir_op_e'(req_op_i[int'(win)*2 +: 2]);
          core_d  = req_core_i[int'(win)*CW +: CW];
          dirty_d = req_dirty_i[win];
          id_d    = win;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        old_d   = rd_e;
        wr_d    = upd.entry;
        cf_d    = upd.conflict | chk_bad;
        we_d    = upd.write & ~chk_bad;
        err_d   = err_q | chk_bad;
        state_d = ST_WR;
      end
      ST_WR: begin
        we_d    = 1'b0;
        rv_d    = 1'b1;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (resp_ready_i) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      op_q    <= OP_READ;
      core_q  <= '0;
      dirty_q <= 1'b0;
      id_q    <= '0;
      old_q   <= '0;
      wr_q    <= '0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      cf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      op_q    <= op_d;
      core_q  <= core_d;
      dirty_q <= dirty_d;
      id_q    <= id_d;
      old_q   <= old_d;
      wr_q    <= wr_d;
      we_q    <= we_d;
      rv_q    <= rv_d;
      cf_q    <= cf_d;
      err_q   <= err_d;
    end
  end

  assign dir_rd_set_o         = set_q;
  assign dir_we_o             = we_q;
  assign dir_wr_set_o         = set_q;
  assign dir_wr_way_o         = way_q;
  assign dir_wr_valid_o       = wr_q.valid;
  assign dir_wr_sharers_o     = wr_q.sharers;
  assign dir_wr_owner_valid_o = wr_q.owner_valid;
  assign dir_wr_owner_id_o    = wr_q.owner_id;
  assign dir_wr_dirty_o       = wr_q.dirty;
  assign resp_valid_o         = rv_q;
  assign resp_id_o            = id_q;
  assign resp_hit_o           = old_q.valid;
  assign resp_sharers_o       = old_q.sharers;
  assign resp_owner_valid_o   = old_q.owner_valid;
  assign resp_owner_id_o      = old_q.owner_id;
  assign resp_dirty_o         = old_q.dirty;
  assign resp_conflict_o      = cf_q;
  assign err_o                = err_q;

endmodule

// File: tb/tb_rv64g_l2_dir_ctrl.sv
// Bench for rv64g_l2_dir_ctrl: directory RAM model, transaction-level
// reference model with per-cycle compare, plus directed literal checks.
module tb_rv64g_l2_dir_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid_i;
  logic [2:0]  req_ready_o;
  logic [23:0] req_set_i;
  logic [11:0] req_way_i;
  logic [5:0]  req_op_i;
  logic [5:0]  req_core_i;
  logic [2:0]  req_dirty_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [1:0]  resp_id_o;
  logic        resp_hit_o;
  logic [3:0]  resp_sharers_o;
  logic        resp_owner_valid_o;
  logic [1:0]  resp_owner_id_o;
  logic        resp_dirty_o;
  logic        resp_conflict_o;
  logic [7:0]  dir_rd_set_o;
  logic [15:0] dir_rd_valid_i;
  logic [63:0] dir_rd_sharers_i;
  logic [15:0] dir_rd_owner_valid_i;
  logic [31:0] dir_rd_owner_id_i;
  logic [15:0] dir_rd_dirty_i;
  logic        dir_we_o;
  logic [7:0]  dir_wr_set_o;
  logic [3:0]  dir_wr_way_o;
  logic        dir_wr_valid_o;
  logic [3:0]  dir_wr_sharers_o;
  logic        dir_wr_owner_valid_o;
  logic [1:0]  dir_wr_owner_id_o;
  logic        dir_wr_dirty_o;
  logic        err_o;

  rv64g_l2_dir_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_set_i(req_set_i), .req_way_i(req_way_i),
    .req_op_i(req_op_i), .req_core_i(req_core_i),
    .req_dirty_i(req_dirty_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_id_o(resp_id_o), .resp_hit_o(resp_hit_o),
    .resp_sharers_o(resp_sharers_o),
    .resp_owner_valid_o(resp_owner_valid_o),
    .resp_owner_id_o(resp_owner_id_o), .resp_dirty_o(resp_dirty_o),
    .resp_conflict_o(resp_conflict_o),
    .dir_rd_set_o(dir_rd_set_o), .dir_rd_valid_i(dir_rd_valid_i),
    .dir_rd_sharers_i(dir_rd_sharers_i),
    .dir_rd_owner_valid_i(dir_rd_owner_valid_i),
    .dir_rd_owner_id_i(dir_rd_owner_id_i),
    .dir_rd_dirty_i(dir_rd_dirty_i),
    .dir_we_o(dir_we_o), .dir_wr_set_o(dir_wr_set_o),
    .dir_wr_way_o(dir_wr_way_o), .dir_wr_valid_o(dir_wr_valid_o),
    .dir_wr_sharers_o(dir_wr_sharers_o),
    .dir_wr_owner_valid_o(dir_wr_owner_valid_o),
    .dir_wr_owner_id_o(dir_wr_owner_id_o),
    .dir_wr_dirty_o(dir_wr_dirty_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit       v;
    bit [3:0] sh;
    bit       ov;
    bit [1:0] oid;
    bit       d;
  } ent_t;

  ent_t mem [256][16];
  ent_t shd [256][16];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic ent_t mk(bit v, bit [3:0] sh, bit ov,
                              bit [1:0] oid, bit d);
    ent_t e;
    e.v = v; e.sh = sh; e.ov = ov; e.oid = oid; e.d = d;
    return e;
  endfunction

  always_comb begin
    dir_rd_valid_i       = '0;
    dir_rd_sharers_i     = '0;
    dir_rd_owner_valid_i = '0;
    dir_rd_owner_id_i    = '0;
    dir_rd_dirty_i       = '0;
    for (int w = 0; w < 16; w++) begin
      dir_rd_valid_i[w]         = mem[dir_rd_set_o][w].v;
      dir_rd_sharers_i[w*4 +: 4] = mem[dir_rd_set_o][w].sh;
      dir_rd_owner_valid_i[w]   = mem[dir_rd_set_o][w].ov;
      dir_rd_owner_id_i[w*2 +: 2] = mem[dir_rd_set_o][w].oid;
      dir_rd_dirty_i[w]         = mem[dir_rd_set_o][w].d;
    end
  end

  always @(posedge clk) begin
    if (dir_we_o)
      mem[dir_wr_set_o][dir_wr_way_o] <= mk(dir_wr_valid_o,
        dir_wr_sharers_o, dir_wr_owner_valid_o,
        dir_wr_owner_id_o, dir_wr_dirty_o);
  end

  // Reference: directory rules applied to a whole transaction at once.
  function automatic void model_op(input ent_t o, input int op,
      input int core, input bit dirty, output ent_t n,
      output bit cf, output bit wr);
    bit [3:0] b;
    b = 4'b0001 << core;
    n = o; cf = 1'b0; wr = 1'b0;
    case (op)
      1: if (o.ov && int'(o.oid) != core) cf = 1'b1;
         else begin
           n = mk(1'b1, o.sh | b, 1'b0, 2'd0, 1'b0); wr = 1'b1;
         end
      2: begin n = mk(1'b1, 4'd0, 1'b1, 2'(core), dirty); wr = 1'b1; end
      3: begin
        n.sh = o.sh & ~b;
        if (o.ov && int'(o.oid) == core) begin n.ov = 1'b0; n.d = 1'b0; end
        wr = 1'b1;
      end
      default: ;
    endcase
  endfunction

  int   phase = 0, rr = 0, resp_count = 0, cyc = 0;
  bit   exp_err = 1'b0;
  int   t_id, t_set, t_way, t_op, t_core;
  bit   t_dirty, t_cf, t_wr, t_bad;
  ent_t t_old, t_new;
  int   acc_cyc, we_cyc, rv_cyc;
  bit   rv_prev, we_seen, last_cf;
  ent_t last_wr, last_rsp;
  int   dut_gnt[$];

  always @(negedge clk) begin
    logic [2:0] exp_ready;
    int nph, w;
    bit found;
    if (!rst_n) begin
      chk("rst_ready", req_ready_o, 0);
      chk("rst_resp_valid", resp_valid_o, 0);
      chk("rst_we", dir_we_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_rd_set", dir_rd_set_o, 0);
      chk("rst_resp_cf", resp_conflict_o, 0);
      if ((phase == 1 || phase == 2) && t_wr) shd[t_set][t_way] = t_old;
      phase = 0; rr = 0; exp_err = 1'b0; rv_prev = 1'b0;
    end else begin
      cyc++;
      exp_ready = '0;
      nph = phase;
      if (|req_ready_o) begin
        acc_cyc = cyc;
        for (int k = 0; k < 3; k++) if (req_ready_o[k]) dut_gnt.push_back(k);
      end
      if (dir_we_o) we_cyc = cyc;
      if (resp_valid_o && !rv_prev) rv_cyc = cyc;
      rv_prev = resp_valid_o;
      case (phase)
        0: if (|req_valid_i) begin
          found = 1'b0; w = 0;
          for (int k = 0; k < 3; k++)
            if (!found && req_valid_i[(rr + k) % 3]) begin
              found = 1'b1; w = (rr + k) % 3;
            end
          exp_ready[w] = 1'b1;
          t_id = w;
          t_set = int'(req_set_i[w*8 +: 8]);
          t_way = int'(req_way_i[w*4 +: 4]);
          t_op = int'(req_op_i[w*2 +: 2]);
          t_core = int'(req_core_i[w*2 +: 2]);
          t_dirty = req_dirty_i[w];
          t_old = shd[t_set][t_way];
          model_op(t_old, t_op, t_core, t_dirty, t_new, t_cf, t_wr);
          t_bad = (t_old.ov && t_old.sh != 0) || (t_old.d && !t_old.ov);
`ifdef L2_DIR_CTRL_CHECK_EN
          if (t_bad) begin t_cf = 1'b1; t_wr = 1'b0; end
`endif
          if (t_wr) shd[t_set][t_way] = t_new;
          rr = (w + 1) % 3;
          nph = 1;
        end
        1: nph = 2;
        2: begin
`ifdef L2_DIR_CTRL_CHECK_EN
          if (t_bad) exp_err = 1'b1;
`endif
          we_seen = dir_we_o;
          last_wr = mk(dir_wr_valid_o, dir_wr_sharers_o,
                       dir_wr_owner_valid_o, dir_wr_owner_id_o,
                       dir_wr_dirty_o);
          if (t_wr) begin
            chk("wr_set", dir_wr_set_o, t_set);
            chk("wr_way", dir_wr_way_o, t_way);
            chk("wr_entry", last_wr, t_new);
          end
          nph = 3;
        end
        default: begin
          chk("resp_id", resp_id_o, t_id);
          chk("resp_entry", mk(resp_hit_o, resp_sharers_o,
              resp_owner_valid_o, resp_owner_id_o, resp_dirty_o), t_old);
          chk("resp_cf", resp_conflict_o, t_cf);
          if (resp_ready_i) begin
            last_rsp = mk(resp_hit_o, resp_sharers_o, resp_owner_valid_o,
                          resp_owner_id_o, resp_dirty_o);
            last_cf = resp_conflict_o;
            resp_count++;
            nph = 0;
          end
        end
      endcase
      chk("ready", req_ready_o, exp_ready);
      chk("we", dir_we_o, phase == 2 && t_wr);
      chk("resp_valid", resp_valid_o, phase == 3);
      chk("err", err_o, exp_err);
      if (phase != 0) chk("rd_set", dir_rd_set_o, t_set);
      phase = nph;
    end
  end

  task automatic preload(input int s, input int w, input ent_t e);
    mem[s][w] = e;
    shd[s][w] = e;
  endtask

  task automatic set_req(input int r, input int s, input int w,
      input int op, input int core, input bit d);
    req_set_i[r*8 +: 8]  = 8'(s);
    req_way_i[r*4 +: 4]  = 4'(w);
    req_op_i[r*2 +: 2]   = 2'(op);
    req_core_i[r*2 +: 2] = 2'(core);
    req_dirty_i[r]       = d;
  endtask

  task automatic issue(input int r, input int s, input int w,
      input int op, input int core, input bit d);
    set_req(r, s, w, op, core, d);
    req_valid_i[r] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready_o[r]) break;
    end
    chk($sformatf("accept%0d", r), req_ready_o[r], 1);
    @(posedge clk); #1;
    req_valid_i[r] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      if (resp_count >= target) break;
    end
    #1;
    chk("op_done", resp_count, target);
  endtask

  task automatic do_op(input int r, input int s, input int w,
      input int op, input int core, input bit d);
    int start;
    start = resp_count;
    issue(r, s, w, op, core, d);
    wait_done(start + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int start, base;
    rst_n = 1'b0;
    resp_ready_i = 1'b1;
    req_set_i = '0; req_way_i = '0; req_op_i = '0;
    req_core_i = '0; req_dirty_i = '0;
    req_valid_i = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset_ready_lit", req_ready_o, 3'b000);
    #2 req_valid_i = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    do_op(0, 10, 5, 1, 1, 1'b0);
    chk("t2_we_seen", we_seen, 1);
    chk("t2_wr_sh", last_wr.sh, 4'b0010);
    chk("t2_wr_v", last_wr.v, 1);
    chk("t2_hit", last_rsp.v, 0);
    chk("t2_cf", last_cf, 0);
    chk("t2_we_lat", we_cyc - acc_cyc, 2);
    chk("t2_rv_lat", rv_cyc - acc_cyc, 3);

    do_op(1, 10, 5, 2, 2, 1'b0);
    do_op(0, 10, 5, 1, 3, 1'b0);
    chk("t3_cf", last_cf, 1);
    chk("t3_we_seen", we_seen, 0);
    chk("t3_old_oid", last_rsp.oid, 2);

    preload(30, 2, mk(1'b1, 4'b1010, 1'b0, 2'd0, 1'b0));
    do_op(2, 30, 2, 2, 2, 1'b1);
    chk("t4_wr_sh", last_wr.sh, 4'b0000);
    chk("t4_wr_oid", last_wr.oid, 2);
    chk("t4_wr_d", last_wr.d, 1);
    chk("t4_rsp_sh", last_rsp.sh, 4'b1010);

    start = resp_count;
    base = dut_gnt.size();
    resp_ready_i = 1'b0;
    set_req(0, 20, 0, 1, 0, 1'b0);
    set_req(1, 20, 0, 1, 1, 1'b0);
    set_req(2, 20, 0, 0, 0, 1'b0);
    req_valid_i = 3'b111;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid_o) break;
    end
    chk("t5_rv_up", resp_valid_o, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_stall_rv", resp_valid_o, 1);
      chk("t5_stall_ready", req_ready_o, 0);
    end
    @(posedge clk); #1 resp_ready_i = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      if (dut_gnt.size() - base >= 4) break;
    end
    #1 req_valid_i = '0;
    wait_done(start + 4);
    chk("t5_g0", dut_gnt[base], 0);
    chk("t5_g1", dut_gnt[base+1], 1);
    chk("t5_g2", dut_gnt[base+2], 2);
    chk("t5_g3", dut_gnt[base+3], 0);

    preload(40, 3, mk(1'b1, 4'b0001, 1'b1, 2'd0, 1'b0));
    do_op(0, 40, 3, 1, 0, 1'b0);
    repeat (3) @(posedge clk); #1;
`ifdef L2_DIR_CTRL_CHECK_EN
    chk("t6_cf", last_cf, 1);
    chk("t6_we_seen", we_seen, 0);
    chk("t6_err_sticky", err_o, 1);
`else
    chk("t6_cf", last_cf, 0);
    chk("t6_we_seen", we_seen, 1);
    chk("t6_err", err_o, 0);
`endif

    start = resp_count;
    issue(1, 50, 1, 2, 3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (phase == 2) break;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t7_we", dir_we_o, 0);
    chk("t7_rv", resp_valid_o, 0);
    chk("t7_err", err_o, 0);
    @(posedge clk); #2;
    chk("t7_no_write", mem[50][1].ov, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("t7_no_resp", resp_count, start);
    do_op(2, 10, 5, 0, 0, 1'b0);
    chk("t7_after_ov", last_rsp.ov, 1);
    chk("t7_after_oid", last_rsp.oid, 2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
